// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the fetch/load-store requesters, the memory block
// and mem_arbiter. The arbiter connects through the slave modport; the
// requester/memory side uses master.
interface mem_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  // fetch requester
  logic                 if_req;
  logic [BUS_WIDTH-1:0] if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [BUS_WIDTH-1:0] if_rdata;
  logic                 if_err;
  // load/store requester
  logic                 d_req;
  logic                 d_we;
  logic [BUS_WIDTH-1:0] d_addr;
  logic [BUS_WIDTH-1:0] d_wdata;
  logic [1:0]           d_size;
  logic                 d_sign;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [BUS_WIDTH-1:0] d_rdata;
  logic                 d_err;
  // memory port
  logic                 mem_rd;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_data;
  logic [1:0]           mem_size;
  logic                 mem_sign;
  logic [BUS_WIDTH-1:0] mem_out;
  logic                 mem_error;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_size, d_sign,
    input  mem_out, mem_error,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_rd, mem_we, mem_addr, mem_data, mem_size, mem_sign
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_size, d_sign,
    output mem_out, mem_error,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_rd, mem_we, mem_addr, mem_data, mem_size, mem_sign
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer sharing one OTTER memory port between the
// instruction-fetch path (read-only) and the load/store path. One transaction
// at a time: IDLE (grant) -> ISSUE (strobe) -> WAIT (latency) -> RESP.
module mem_arbiter #(
  parameter int BUS_WIDTH   = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

  state_t               state_q;
  src_t                 src_q;
  src_t                 last_q;
  logic [CW-1:0]        cnt_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic                 we_q;
  logic [1:0]           size_q;
  logic                 sign_q;

  logic                 if_rvalid_q, d_rvalid_q;
  logic [BUS_WIDTH-1:0] if_rdata_q, d_rdata_q;
  logic                 if_err_q, d_err_q;

  logic                 grant_if, grant_d;
  logic                 resp_fire, resp_err;
  logic [BUS_WIDTH-1:0] resp_data;

  // Arbitration in IDLE; a tie goes to whoever was not granted last.
  // Gated by rst_n so gnt stays low while reset is held.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (bus.if_req && bus.d_req) begin
        if (last_q == SRC_DATA) grant_if = 1'b1;
        else                    grant_d  = 1'b1;
      end else begin
        grant_if = bus.if_req;
        grant_d  = bus.d_req;
      end
    end
  end

  // Response payload: error abort from ISSUE, or data capture at end of WAIT.
  always_comb begin
    resp_fire = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    if (state_q == ISSUE && bus.mem_error) begin
      resp_fire = 1'b1;
      resp_err  = 1'b1;
    end else if (state_q == WAIT && cnt_q == CW'(MEM_LATENCY)) begin
      resp_fire = 1'b1;
      resp_data = we_q ? '0 : bus.mem_out;
    end
  end

  // Sequencer FSM with latched request state and per-port response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_FETCH;
      last_q      <= SRC_DATA;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_if) begin
            src_q   <= SRC_FETCH;
            addr_q  <= bus.if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b10;
            sign_q  <= 1'b0;
            state_q <= ISSUE;
          end else if (grant_d) begin
            src_q   <= SRC_DATA;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            we_q    <= bus.d_we;
            size_q  <= bus.d_size;
            sign_q  <= bus.d_sign;
            state_q <= ISSUE;
          end
          if (bus.if_req && bus.d_req) last_q <= grant_if ? SRC_FETCH : SRC_DATA;
        end
        ISSUE: begin
          if (bus.mem_error) begin
            state_q <= RESP;
          end else begin
            cnt_q   <= CW'(1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (resp_fire) state_q <= RESP;
          else           cnt_q   <= cnt_q + CW'(1);
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (resp_fire) begin
        if (src_q == SRC_FETCH) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= resp_data;
          if_err_q    <= resp_err;
        end else begin
          d_rvalid_q  <= 1'b1;
          d_rdata_q   <= resp_data;
          d_err_q     <= resp_err;
        end
      end
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;

  assign bus.mem_rd   = (state_q == ISSUE) && !bus.mem_error && !we_q;
  assign bus.mem_we   = (state_q == ISSUE) && !bus.mem_error &&  we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = wdata_q;
  assign bus.mem_size = size_q;
  assign bus.mem_sign = sign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-1 instance with a byte-addressed
// 8 KiB memory model, and a latency-2 instance used for the reset-abort case.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.BUS_WIDTH(32)) bus1 ();
  mem_arbiter_if #(.BUS_WIDTH(32)) bus2 ();

  mem_arbiter #(.BUS_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  mem_arbiter #(.BUS_WIDTH(32), .MEM_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
  );

  // Memory model: 13-bit byte address space, alignment/range error, 1-cycle read.
  logic [7:0]  mem [0:8191];
  logic [31:0] m1_out;
  logic        m1_err;
  logic [31:0] m1_rd;
  logic [12:0] ma;

  always_comb begin
    ma     = bus1.mem_addr[12:0];
    m1_err = (bus1.mem_addr >= 32'h2000) || (bus1.mem_size == 2'b11) ||
             (bus1.mem_size == 2'b01 && bus1.mem_addr[0]) ||
             (bus1.mem_size == 2'b10 && bus1.mem_addr[1:0] != 2'b00);
    m1_rd  = '0;
    case (bus1.mem_size)
      2'b00:   m1_rd = {{24{bus1.mem_sign & mem[ma][7]}}, mem[ma]};
      2'b01:   m1_rd = {{16{bus1.mem_sign & mem[ma+13'd1][7]}}, mem[ma+13'd1], mem[ma]};
      default: m1_rd = {mem[ma+13'd3], mem[ma+13'd2], mem[ma+13'd1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hEF; mem[17] <= 8'hBE; mem[18] <= 8'hAD; mem[19] <= 8'hDE;
      mem[20] <= 8'h78; mem[21] <= 8'h56; mem[22] <= 8'h34; mem[23] <= 8'h12;
      m1_out  <= '0;
    end else begin
      if (bus1.mem_we && !m1_err) begin
        mem[ma] <= bus1.mem_data[7:0];
        if (bus1.mem_size != 2'b00) mem[ma+13'd1] <= bus1.mem_data[15:8];
        if (bus1.mem_size == 2'b10) begin
          mem[ma+13'd2] <= bus1.mem_data[23:16];
          mem[ma+13'd3] <= bus1.mem_data[31:24];
        end
      end
      if (bus1.mem_rd && !m1_err) m1_out <= m1_rd;
    end
  end

  assign bus1.mem_out   = m1_out;
  assign bus1.mem_error = m1_err;
  assign bus2.mem_out   = 32'h5A5A5A5A;
  assign bus2.mem_error = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive point is 2 time units after the rising edge; sample at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_size = 2'b10; bus1.d_sign = 1'b0;
    bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_addr = '0; bus2.d_wdata = '0; bus2.d_size = 2'b10; bus2.d_sign = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_if_gnt",    32'(bus1.if_gnt),    32'd0);
    chk("rst_if_rvalid", 32'(bus1.if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(bus1.d_rvalid),  32'd0);
    chk("rst_mem_rd",    32'(bus1.mem_rd),    32'd0);
    chk("rst_mem_addr",  bus1.mem_addr,       32'd0);
    chk("rst_mem_size",  32'(bus1.mem_size),  32'd0);
    chk("rst_d_rdata",   bus1.d_rdata,        32'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // fetch only
    cyc(); bus1.if_req = 1'b1; bus1.if_addr = 32'h10; settle();
    chk("f_if_gnt", 32'(bus1.if_gnt), 32'd1);
    chk("f_d_gnt",  32'(bus1.d_gnt),  32'd0);
    chk("f_rd_c0",  32'(bus1.mem_rd), 32'd0);
    cyc(); bus1.if_req = 1'b0; settle();
    chk("f_rd_c1",   32'(bus1.mem_rd),   32'd1);
    chk("f_addr_c1", bus1.mem_addr,      32'h10);
    chk("f_size_c1", 32'(bus1.mem_size), 32'd2);
    chk("f_gnt_c1",  32'(bus1.if_gnt),   32'd0);
    cyc(); settle();
    chk("f_rv_c2", 32'(bus1.if_rvalid), 32'd0);
    cyc(); settle();
    chk("f_rv_c3",    32'(bus1.if_rvalid), 32'd1);
    chk("f_rdata_c3", bus1.if_rdata,       32'hDEADBEEF);
    chk("f_err_c3",   32'(bus1.if_err),    32'd0);
    chk("f_drv_c3",   32'(bus1.d_rvalid),  32'd0);
    cyc(); settle();
    chk("f_rv_c4",   32'(bus1.if_rvalid), 32'd0);
    chk("f_hold_c4", bus1.if_rdata,       32'hDEADBEEF);

    // tie with round-robin over three transactions: fetch, data, fetch
    cyc();
    bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h14; bus1.d_size = 2'b10; bus1.d_sign = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (t > 0) cyc();
      if (t == 9) begin bus1.if_req = 1'b0; bus1.d_req = 1'b0; end
      settle();
      chk($sformatf("rr_if_gnt_t%0d", t), 32'(bus1.if_gnt),    32'(t == 0 || t == 8));
      chk($sformatf("rr_d_gnt_t%0d", t),  32'(bus1.d_gnt),     32'(t == 4));
      chk($sformatf("rr_if_rv_t%0d", t),  32'(bus1.if_rvalid), 32'(t == 3 || t == 11));
      chk($sformatf("rr_d_rv_t%0d", t),   32'(bus1.d_rvalid),  32'(t == 7));
      chk($sformatf("rr_rd_t%0d", t),     32'(bus1.mem_rd),    32'(t % 4 == 1));
      if (t == 7)  chk("rr_d_rdata",  bus1.d_rdata,  32'h12345678);
      if (t == 11) chk("rr_if_rdata", bus1.if_rdata, 32'hDEADBEEF);
    end

    // misaligned word store
    cyc();
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h6; bus1.d_size = 2'b10; bus1.d_wdata = 32'h11223344;
    settle();
    chk("ms_d_gnt", 32'(bus1.d_gnt), 32'd1);
    cyc(); bus1.d_req = 1'b0; settle();
    chk("ms_we_c1", 32'(bus1.mem_we), 32'd0);
    chk("ms_rd_c1", 32'(bus1.mem_rd), 32'd0);
    cyc(); settle();
    chk("ms_rv_c2",    32'(bus1.d_rvalid),  32'd1);
    chk("ms_err_c2",   32'(bus1.d_err),     32'd1);
    chk("ms_rdata_c2", bus1.d_rdata,        32'd0);
    chk("ms_ifrv_c2",  32'(bus1.if_rvalid), 32'd0);

    // byte store then signed byte load
    cyc();
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h3; bus1.d_size = 2'b00; bus1.d_wdata = 32'hAB;
    settle();
    chk("bs_d_gnt", 32'(bus1.d_gnt), 32'd1);
    cyc(); bus1.d_req = 1'b0; settle();
    chk("bs_we_c1",   32'(bus1.mem_we),   32'd1);
    chk("bs_size_c1", 32'(bus1.mem_size), 32'd0);
    chk("bs_addr_c1", bus1.mem_addr,      32'h3);
    chk("bs_data_c1", bus1.mem_data,      32'hAB);
    cyc(); settle();
    chk("bs_we_c2", 32'(bus1.mem_we), 32'd0);
    cyc(); settle();
    chk("bs_rv_c3",    32'(bus1.d_rvalid), 32'd1);
    chk("bs_err_c3",   32'(bus1.d_err),    32'd0);
    chk("bs_rdata_c3", bus1.d_rdata,       32'd0);
    cyc();
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h3; bus1.d_size = 2'b00; bus1.d_sign = 1'b1;
    settle();
    chk("bl_d_gnt", 32'(bus1.d_gnt), 32'd1);
    cyc(); bus1.d_req = 1'b0; settle();
    chk("bl_rd_c1",   32'(bus1.mem_rd),   32'd1);
    chk("bl_sign_c1", 32'(bus1.mem_sign), 32'd1);
    cyc(); cyc(); settle();
    chk("bl_rv_c3",    32'(bus1.d_rvalid), 32'd1);
    chk("bl_rdata_c3", bus1.d_rdata,       32'hFFFFFFAB);
    chk("bl_err_c3",   32'(bus1.d_err),    32'd0);

    // out-of-range load
    cyc();
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h4000; bus1.d_size = 2'b10; bus1.d_sign = 1'b0;
    settle();
    chk("or_d_gnt", 32'(bus1.d_gnt), 32'd1);
    cyc(); bus1.d_req = 1'b0; settle();
    chk("or_rd_c1", 32'(bus1.mem_rd), 32'd0);
    chk("or_we_c1", 32'(bus1.mem_we), 32'd0);
    cyc(); settle();
    chk("or_rv_c2",    32'(bus1.d_rvalid), 32'd1);
    chk("or_err_c2",   32'(bus1.d_err),    32'd1);
    chk("or_rdata_c2", bus1.d_rdata,       32'd0);

    // misaligned fetch clears previously held fetch data
    cyc(); bus1.if_req = 1'b1; bus1.if_addr = 32'h12; settle();
    chk("fe_if_gnt", 32'(bus1.if_gnt), 32'd1);
    cyc(); bus1.if_req = 1'b0; settle();
    chk("fe_rd_c1", 32'(bus1.mem_rd), 32'd0);
    cyc(); settle();
    chk("fe_rv_c2",    32'(bus1.if_rvalid), 32'd1);
    chk("fe_err_c2",   32'(bus1.if_err),    32'd1);
    chk("fe_rdata_c2", bus1.if_rdata,       32'd0);

    // latency-2 instance: full fetch
    cyc(); bus2.if_req = 1'b1; bus2.if_addr = 32'h20; settle();
    chk("l2_gnt", 32'(bus2.if_gnt), 32'd1);
    cyc(); bus2.if_req = 1'b0; settle();
    chk("l2_rd_c1", 32'(bus2.mem_rd), 32'd1);
    cyc(); settle();
    chk("l2_rv_c2", 32'(bus2.if_rvalid), 32'd0);
    cyc(); settle();
    chk("l2_rv_c3", 32'(bus2.if_rvalid), 32'd0);
    cyc(); settle();
    chk("l2_rv_c4",    32'(bus2.if_rvalid), 32'd1);
    chk("l2_rdata_c4", bus2.if_rdata,       32'h5A5A5A5A);

    // reset while in WAIT
    cyc(); bus2.if_req = 1'b1; bus2.if_addr = 32'h24; settle();
    chk("ra_gnt", 32'(bus2.if_gnt), 32'd1);
    cyc(); bus2.if_req = 1'b0; settle();
    chk("ra_rd_c1", 32'(bus2.mem_rd), 32'd1);
    cyc(); rst2_n = 1'b0; settle();
    chk("ra_mem_addr", bus2.mem_addr,       32'd0);
    chk("ra_mem_size", 32'(bus2.mem_size),  32'd0);
    chk("ra_mem_rd",   32'(bus2.mem_rd),    32'd0);
    chk("ra_if_rv",    32'(bus2.if_rvalid), 32'd0);
    chk("ra_if_rdata", bus2.if_rdata,       32'd0);
    cyc(); rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("ra_post_if_rv_%0d", k), 32'(bus2.if_rvalid), 32'd0);
      chk($sformatf("ra_post_d_rv_%0d", k),  32'(bus2.d_rvalid),  32'd0);
      chk($sformatf("ra_post_rd_%0d", k),    32'(bus2.mem_rd),    32'd0);
      cyc();
    end
    bus2.if_req = 1'b1; bus2.if_addr = 32'h28;
    bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 32'h2C; bus2.d_size = 2'b10;
    settle();
    chk("ra_tie_if_gnt", 32'(bus2.if_gnt), 32'd1);
    chk("ra_tie_d_gnt",  32'(bus2.d_gnt),  32'd0);
    cyc(); bus2.if_req = 1'b0; bus2.d_req = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
